// File: rtl/apu_regops_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apu_regops_pkg
// Purpose  : Shared constants, command record and sweep helpers for the
//            APU register-space bus initiator.
// Revision : 1.0 - initial release
// ============================================================================
package apu_regops_pkg;

  localparam logic [15:0] APU_REG_BASE = 16'h4000;
  localparam logic [15:0] APU_REG_LAST = 16'h401F;
  localparam logic [15:0] IDLE_ADDR    = 16'h0000;

  // One queued register operation: rw=1 read, rw=0 write.
  typedef struct packed {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  data;
  } apu_cmd_t;

  // Dummy read placed on the bus whenever no command is available.
  localparam apu_cmd_t IDLE_CMD = '{rw: 1'b1, addr: IDLE_ADDR, data: 8'h00};

  typedef enum logic [1:0] {
    SW_IDLE = 2'd0,
    SW_PEND = 2'd1,
    SW_RUN  = 2'd2
  } sweep_state_t;

  // Sweep step idx: 0..31 read BASE+idx, 32..63 write BASE+(idx-32) with
  // data equal to the low address byte.
  function automatic apu_cmd_t make_sweep_cmd(input logic [5:0] idx);
    apu_cmd_t c;
    c.rw   = ~idx[5];
    c.addr = APU_REG_BASE | {11'd0, idx[4:0]};
    c.data = idx[5] ? c.addr[7:0] : 8'h00;
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apu_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : apu_cmd_fifo
// Purpose  : Synchronous FIFO of apu_cmd_t records with full/empty flags.
//            DEPTH must be a power of two and at least 2.
// Revision : 1.0 - initial release
// ============================================================================
module apu_cmd_fifo
  import apu_regops_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  apu_cmd_t din,
  input  logic     pop,
  output apu_cmd_t dout,
  output logic     full,
  output logic     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] C_DEPTH = (PTR_W + 1)'(DEPTH);

  apu_cmd_t         mem_q [DEPTH];
  apu_cmd_t         mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == C_DEPTH);
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // Pointer/occupancy update; simultaneous push and pop both take effect.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset flushes the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/apu_reg_initiator.sv
`default_nettype none
// ============================================================================
// Module   : apu_reg_initiator
// Purpose  : CPU-side initiator replaying queued register commands as
//            6502-style PHI1/PHI2 bus cycles, returning captured read data.
//            Optional internal register sweep: define APU_REGOPS_SWEEP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module apu_reg_initiator
  import apu_regops_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int HALF  = 2
) (
  input  logic        CLK,
  input  logic        nRES,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  input  logic        sweep_start,
  output logic        PHI1,
  output logic        PHI2,
  output logic [15:0] Addr,
  output logic        RnW,
  output logic [7:0]  DB_out,
  output logic        DB_oe,
  input  logic [7:0]  DB_in,
  output logic        rsp_valid,
  output logic        rsp_rw,
  output logic [15:0] rsp_addr,
  output logic [7:0]  rsp_data,
  output logic        busy,
  output logic        sweep_busy
);

  localparam int CNT_W = (2 * HALF > 2) ? $clog2(2 * HALF) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(2 * HALF - 1);
  localparam logic [CNT_W-1:0] C_CNT_HALF = CNT_W'(HALF);

  // run_q holds the phase counter at 0 for the first clock after reset so the
  // first bus cycle starts with a full PHI1.
  logic             run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  apu_cmd_t         cur_q, cur_d;
  logic             acc_q, acc_d;
  logic             rsp_valid_q, rsp_valid_d;
  apu_cmd_t         rsp_q, rsp_d;

  logic             boundary;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  apu_cmd_t         fifo_din, fifo_dout;
  logic             sweep_load, sweep_hold;
  apu_cmd_t         sweep_cmd;

  assign boundary  = run_q && (cnt_q == C_CNT_LAST);
  assign fifo_din  = '{rw: cmd_rw, addr: cmd_addr, data: cmd_data};
  assign fifo_push = cmd_valid && cmd_ready;
  assign cmd_ready = !fifo_full && !sweep_hold;
  assign busy      = !fifo_empty || acc_q || rsp_valid_q || sweep_hold;

  apu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (nRES),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef APU_REGOPS_SWEEP_EN
  sweep_state_t sw_state_q, sw_state_d;
  logic [5:0]   sw_idx_q, sw_idx_d;

  assign sweep_cmd  = make_sweep_cmd(sw_idx_q);
  assign sweep_hold = (sw_state_q != SW_IDLE);
  assign sweep_busy = (sw_state_q == SW_RUN);

  // Sweep sequencer: wait for the next cycle boundary, then feed 64 steps
  // back-to-back; the index wrapping to 0 marks the end of the run.
  always_comb begin
    sw_state_d = sw_state_q;
    sw_idx_d   = sw_idx_q;
    sweep_load = 1'b0;
    case (sw_state_q)
      SW_IDLE: begin
        if (sweep_start && !busy) sw_state_d = SW_PEND;
      end
      SW_PEND: begin
        if (boundary) begin
          sweep_load = 1'b1;
          sw_idx_d   = sw_idx_q + 6'd1;
          sw_state_d = SW_RUN;
        end
      end
      SW_RUN: begin
        if (boundary) begin
          if (sw_idx_q == 6'd0) begin
            sw_state_d = SW_IDLE;
          end else begin
            sweep_load = 1'b1;
            sw_idx_d   = sw_idx_q + 6'd1;
          end
        end
      end
      default: sw_state_d = SW_IDLE;
    endcase
  end

  // Sweep state register.
  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      sw_state_q <= SW_IDLE;
      sw_idx_q   <= 6'd0;
    end else begin
      sw_state_q <= sw_state_d;
      sw_idx_q   <= sw_idx_d;
    end
  end
`else
  logic unused_sweep_start;

  assign unused_sweep_start = sweep_start;
  assign sweep_load         = 1'b0;
  assign sweep_cmd          = IDLE_CMD;
  assign sweep_hold         = 1'b0;
  assign sweep_busy         = 1'b0;
`endif

  // Phase counter and cycle sequencer: at each boundary retire the current
  // access into the response register and load the next access or IDLE.
  always_comb begin
    run_d       = 1'b1;
    cnt_d       = cnt_q;
    cur_d       = cur_q;
    acc_d       = acc_q;
    rsp_valid_d = 1'b0;
    rsp_d       = rsp_q;
    fifo_pop    = 1'b0;
    if (run_q) begin
      cnt_d = (cnt_q == C_CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
    if (boundary) begin
      rsp_valid_d = acc_q;
      if (acc_q) begin
        rsp_d.rw   = cur_q.rw;
        rsp_d.addr = cur_q.addr;
        rsp_d.data = cur_q.rw ? DB_in : 8'h00;
      end
      if (sweep_load) begin
        cur_d = sweep_cmd;
        acc_d = 1'b1;
      end else if (!fifo_empty) begin
        cur_d    = fifo_dout;
        fifo_pop = 1'b1;
        acc_d    = 1'b1;
      end else begin
        cur_d = IDLE_CMD;
        acc_d = 1'b0;
      end
    end
  end

  // Sequencer registers; reset aborts any access and drops its response.
  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      run_q       <= 1'b0;
      cnt_q       <= '0;
      cur_q       <= IDLE_CMD;
      acc_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      run_q       <= run_d;
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      acc_q       <= acc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign PHI1      = run_q && (cnt_q < C_CNT_HALF);
  assign PHI2      = run_q && (cnt_q >= C_CNT_HALF);
  assign Addr      = cur_q.addr;
  assign RnW       = cur_q.rw;
  assign DB_oe     = acc_q && !cur_q.rw && PHI2;
  assign DB_out    = DB_oe ? cur_q.data : 8'h00;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rw    = rsp_q.rw;
  assign rsp_addr  = rsp_q.addr;
  assign rsp_data  = rsp_q.data;

endmodule
`default_nettype wire

// File: tb/tb_apu_reg_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_apu_reg_initiator
// Purpose  : Directed self-checking bench for apu_reg_initiator (DEPTH=4,
//            HALF=2). Sweep scenario follows APU_REGOPS_SWEEP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apu_reg_initiator;

  localparam int PER = 4;

  logic        CLK = 1'b0;
  logic        nRES = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_rw = 1'b0;
  logic [15:0] cmd_addr = 16'h0000;
  logic [7:0]  cmd_data = 8'h00;
  logic        sweep_start = 1'b0;
  logic [7:0]  DB_in = 8'h00;
  logic        cmd_ready, PHI1, PHI2, RnW, DB_oe, rsp_valid, rsp_rw, busy, sweep_busy;
  logic [15:0] Addr, rsp_addr;
  logic [7:0]  DB_out, rsp_data;

  int n_cmp = 0;
  int n_bad = 0;
  int tb_cnt = -1;
  int tb_cyc = 0;

  apu_reg_initiator #(.DEPTH(4), .HALF(2)) dut (
    .CLK (CLK), .nRES (nRES),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_rw (cmd_rw),
    .cmd_addr (cmd_addr), .cmd_data (cmd_data), .sweep_start (sweep_start),
    .PHI1 (PHI1), .PHI2 (PHI2), .Addr (Addr), .RnW (RnW),
    .DB_out (DB_out), .DB_oe (DB_oe), .DB_in (DB_in),
    .rsp_valid (rsp_valid), .rsp_rw (rsp_rw), .rsp_addr (rsp_addr),
    .rsp_data (rsp_data), .busy (busy), .sweep_busy (sweep_busy)
  );

  always #5 CLK = ~CLK;

  // Expected bus phase: first clock after release is phase 0.
  always @(posedge CLK or negedge nRES) begin
    if (!nRES) tb_cnt <= -1;
    else       tb_cnt <= (tb_cnt + 1) % PER;
  end

  always @(posedge CLK) tb_cyc <= tb_cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_phase(input int n);
    for (int i = 0; i < 2 * PER && tb_cnt != n; i++) tick();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_cmp++;
    if ({PHI1, PHI2, Addr, RnW, DB_out, DB_oe} !== {1'b0, 1'b0, 16'h0000, 1'b1, 8'h00, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_bus: got %b %b %h %b %h %b", PHI1, PHI2, Addr, RnW, DB_out, DB_oe);
    end
    n_cmp++;
    if ({cmd_ready, busy, sweep_busy} !== 3'b100) begin
      n_bad++;
      $display("FAIL reset_status: got ready/busy/sweep %b%b%b expected 100", cmd_ready, busy, sweep_busy);
    end
    n_cmp++;
    if ({rsp_valid, rsp_rw, rsp_addr, rsp_data} !== 26'd0) begin
      n_bad++;
      $display("FAIL reset_rsp: got %b %b %h %h expected all zero", rsp_valid, rsp_rw, rsp_addr, rsp_data);
    end
    nRES = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_cmp++;
      if ({PHI1, PHI2, Addr, RnW, DB_oe, rsp_valid} !==
          {(tb_cnt < 2), (tb_cnt >= 2), 16'h0000, 1'b1, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL idle_clk%0d: got phi1=%b phi2=%b addr=%h rnw=%b oe=%b rsp=%b expected phi1=%b phi2=%b idle",
                 k, PHI1, PHI2, Addr, RnW, DB_oe, rsp_valid, (tb_cnt < 2), (tb_cnt >= 2));
      end
    end
  endtask

  task automatic test_access(input logic rw, input logic [15:0] a, input logic [7:0] d,
                             input logic [7:0] rd);
    wait_phase(0);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_data = d;
    tick();
    cmd_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_after_push %h: got %b expected 1", a, busy);
    end
    wait_phase(0);
    for (int p = 0; p < PER; p++) begin
      DB_in = (p == 3) ? rd : ~rd;
      n_cmp++;
      if ({Addr, RnW, DB_oe, DB_out, rsp_valid} !==
          {a, rw, (!rw && p >= 2), ((!rw && p >= 2) ? d : 8'h00), 1'b0}) begin
        n_bad++;
        $display("FAIL access_%h_ph%0d: got addr=%h rnw=%b oe=%b dout=%h rsp=%b", a, p,
                 Addr, RnW, DB_oe, DB_out, rsp_valid);
      end
      tick();
    end
    DB_in = 8'h00;
    n_cmp++;
    if ({rsp_valid, rsp_rw, rsp_addr, rsp_data} !== {1'b1, rw, a, (rw ? rd : 8'h00)}) begin
      n_bad++;
      $display("FAIL rsp_%h: got v=%b rw=%b addr=%h data=%h expected v=1 rw=%b addr=%h data=%h",
               a, rsp_valid, rsp_rw, rsp_addr, rsp_data, rw, a, (rw ? rd : 8'h00));
    end
    n_cmp++;
    if ({Addr, RnW} !== {16'h0000, 1'b1}) begin
      n_bad++;
      $display("FAIL idle_after_%h: got addr=%h rnw=%b expected 0000 1", a, Addr, RnW);
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rsp_pulse_%h: rsp_valid got %b expected 0", a, rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic        brw [5];
    logic [15:0] badr [5];
    logic [7:0]  bdat [5];
    brw[0] = 1'b0; badr[0] = 16'h4000; bdat[0] = 8'h11;
    brw[1] = 1'b1; badr[1] = 16'h4001; bdat[1] = 8'h00;
    brw[2] = 1'b0; badr[2] = 16'h4002; bdat[2] = 8'h22;
    brw[3] = 1'b1; badr[3] = 16'h4003; bdat[3] = 8'h00;
    brw[4] = 1'b0; badr[4] = 16'h4017; bdat[4] = 8'h40;
    DB_in = 8'h3C;
    wait_phase(3);
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          logic acc;
          cmd_valid = 1'b1; cmd_rw = brw[i]; cmd_addr = badr[i]; cmd_data = bdat[i];
          for (int g = 0; g < 20; g++) begin
            acc = cmd_ready;
            tick();
            if (acc) break;
          end
          if (i == 3) begin
            n_cmp++;
            if (cmd_ready !== 1'b0) begin
              n_bad++;
              $display("FAIL b2b_full: cmd_ready got %b expected 0", cmd_ready);
            end
          end
        end
        cmd_valid = 1'b0;
      end
      begin
        int last_cyc;
        last_cyc = 0;
        for (int k = 0; k < 5; k++) begin
          int g;
          for (g = 0; g < 40 && rsp_valid !== 1'b1; g++) tick();
          n_cmp++;
          if ({rsp_valid, rsp_rw, rsp_addr, rsp_data} !==
              {1'b1, brw[k], badr[k], (brw[k] ? 8'h3C : 8'h00)}) begin
            n_bad++;
            $display("FAIL b2b_rsp%0d: got v=%b rw=%b addr=%h data=%h expected rw=%b addr=%h",
                     k, rsp_valid, rsp_rw, rsp_addr, rsp_data, brw[k], badr[k]);
          end
          if (k > 0) begin
            n_cmp++;
            if (tb_cyc - last_cyc !== PER) begin
              n_bad++;
              $display("FAIL b2b_spacing%0d: got %0d clocks expected %0d", k, tb_cyc - last_cyc, PER);
            end
          end
          last_cyc = tb_cyc;
          tick();
        end
      end
    join
    DB_in = 8'h00;
  endtask

  task automatic test_reset_mid_access();
    wait_phase(0);
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 16'h4008; cmd_data = 8'h77;
    tick();
    cmd_rw = 1'b1; cmd_addr = 16'h4009;
    tick();
    cmd_valid = 1'b0;
    wait_phase(2);
    wait_phase(0);
    wait_phase(2);
    n_cmp++;
    if ({Addr, DB_oe, DB_out} !== {16'h4008, 1'b1, 8'h77}) begin
      n_bad++;
      $display("FAIL mid_pre: got addr=%h oe=%b dout=%h expected 4008 1 77", Addr, DB_oe, DB_out);
    end
    nRES = 1'b0;
    #1;
    n_cmp++;
    if ({PHI1, PHI2, Addr, RnW, DB_out, DB_oe} !== {1'b0, 1'b0, 16'h0000, 1'b1, 8'h00, 1'b0}) begin
      n_bad++;
      $display("FAIL mid_reset_bus: got %b %b %h %b %h %b", PHI1, PHI2, Addr, RnW, DB_out, DB_oe);
    end
    n_cmp++;
    if ({cmd_ready, busy, rsp_valid} !== 3'b100) begin
      n_bad++;
      $display("FAIL mid_reset_status: got ready/busy/rsp %b%b%b expected 100", cmd_ready, busy, rsp_valid);
    end
    tick();
    tick();
    nRES = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      n_cmp++;
      if ({rsp_valid, Addr, RnW, DB_oe} !== {1'b0, 16'h0000, 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL mid_after%0d: got rsp=%b addr=%h rnw=%b oe=%b expected idle", k,
                 rsp_valid, Addr, RnW, DB_oe);
      end
    end
  endtask

  task automatic test_sweep();
`ifdef APU_REGOPS_SWEEP_EN
    int  got, busy_clks;
    logic ready_seen;
    got = 0; busy_clks = 0; ready_seen = 1'b0;
    DB_in = 8'hC3;
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    for (int g = 0; g < 600; g++) begin
      if (sweep_busy === 1'b1) busy_clks++;
      if (sweep_busy === 1'b1 && !ready_seen) begin
        ready_seen = 1'b1;
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL sweep_ready: got %b expected 0", cmd_ready);
        end
      end
      if (DB_oe === 1'b1) begin
        n_cmp++;
        if (DB_out !== Addr[7:0]) begin
          n_bad++;
          $display("FAIL sweep_dout_%h: got %h expected %h", Addr, DB_out, Addr[7:0]);
        end
      end
      if (rsp_valid === 1'b1) begin
        n_cmp++;
        if ({rsp_rw, rsp_addr, rsp_data} !==
            {(got < 32), 16'h4000 + 16'(got % 32), ((got < 32) ? 8'hC3 : 8'h00)}) begin
          n_bad++;
          $display("FAIL sweep_rsp%0d: got rw=%b addr=%h data=%h", got, rsp_rw, rsp_addr, rsp_data);
        end
        got++;
      end
      if (got == 64 && busy === 1'b0) break;
      tick();
    end
    DB_in = 8'h00;
    n_cmp++;
    if (got !== 64) begin
      n_bad++;
      $display("FAIL sweep_count: got %0d responses expected 64", got);
    end
    n_cmp++;
    if (busy_clks !== 64 * PER) begin
      n_bad++;
      $display("FAIL sweep_busy_len: got %0d clocks expected %0d", busy_clks, 64 * PER);
    end
`else
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if ({rsp_valid, Addr, RnW, DB_oe, sweep_busy, cmd_ready, busy} !==
          {1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL nosweep%0d: got rsp=%b addr=%h rnw=%b oe=%b sb=%b rdy=%b busy=%b", k,
                 rsp_valid, Addr, RnW, DB_oe, sweep_busy, cmd_ready, busy);
      end
      tick();
    end
`endif
  endtask

  initial begin
    test_reset();
    test_access(1'b0, 16'h4015, 8'h1F, 8'h00);
    test_access(1'b1, 16'h4015, 8'h00, 8'h5A);
    test_access(1'b0, 16'h401F, 8'hE1, 8'h00);
    test_access(1'b1, 16'h4000, 8'h00, 8'hA6);
    test_back_to_back();
    test_reset_mid_access();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
